display_scan_scheduler: RTL and testbench
=========================================

Name: display_scan_scheduler

Overview:
- Sequences the multiplexed 7-segment display.
- Generates the digit scan: anode select, nibble select, anti-ghost blanking and PWM brightness.
- Shares the display between two requesters (A: operand view, B: sum view). Arbitration happens only on frame boundaries, so a frame never mixes sources.
- Output nibble feeds the existing hex-to-segment decoder; the anode bus goes straight to the pins.

Parameters:
- DIGITS, 4: number of scanned digits (fixed at 4 in this revision).
- SLOT_LOG2, 16: log2 of clocks per digit slot; the slot length is 2^SLOT_LOG2 and must be >= 4.
- BLANK_CYCLES, 64: clocks at the start of each slot with all anodes off; must be < 2^(SLOT_LOG2-3).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_a  in  1  requester A wants the display
- data_a  in  16  requester A value, 4 nibbles, digit 0 = [3:0]
- req_b  in  1  requester B wants the display
- data_b  in  16  requester B value
- brightness  in  3  duty level, 0 = 1/8 of slot, 7 = 8/8 of slot
- lz_blank  in  1  1 = suppress leading-zero digits
- grant_a  out  1  frame currently shown is A's
- grant_b  out  1  frame currently shown is B's
- digit  out  4  nibble for the decoder
- an  out  4  active-low anode enables
- frame_done  out  1  one-cycle pulse on the last clock of each frame

Behaviour:
- Reset values: an=4'b1111, digit=0, grant_a=0, grant_b=0, frame_done=0. Internally slot_cnt=0, idx=0, frame_buf=0.
- Counters:
  - slot_cnt increments every clock and wraps at 2^SLOT_LOG2-1.
  - On wrap, idx increments modulo DIGITS.
  - Frame boundary = cycle where idx==DIGITS-1 && slot_cnt==max.
- frame_done is registered and high in the cycle after the boundary condition is true; width is exactly 1 clock.
- Arbitration, evaluated only at the frame boundary:
  - If the current owner still requests, it keeps the grant.
  - Otherwise, if req_a is high, A wins; otherwise, if req_b is high, B wins; otherwise no owner.
  - Both requesting with no current owner: A wins.
  - The new owner's data is copied into frame_buf at the same edge. grant_a/grant_b update on that edge and are mutually exclusive.
  - With no owner: grants are 0 and frame_buf holds the last frame shown (0 after reset).
  - Requester data changes mid-frame are ignored until the next boundary.
- Per-slot phases (phase = slot_cnt[SLOT_LOG2-1 -: 3]):
  - BLANK: slot_cnt < BLANK_CYCLES → an=1111.
  - ON: not blank and phase <= brightness → an = one-cold at bit idx.
  - OFF: otherwise → an=1111.
  - brightness is sampled each cycle; a change mid-slot takes effect on the next clock.
- Leading-zero suppression: with lz_blank=1, digit k>0 is forced OFF for the whole slot when frame_buf nibbles k..3 are all zero. Digit 0 is never suppressed (value 0 shows "0").
- digit = frame_buf nibble idx in every phase, including blank/off, so the decoder input is stable before the anode turns on.
- Latency: an and digit are registered, one clock after the counter state that selects them.
- rst mid-frame: every output returns to its reset value on the next edge, and the scan restarts at idx 0. The first frame after reset shows 0000 with no grant.

Decomposition:
- Package display_pkg:
  - localparams DIGITS=4 and AN_OFF=4'b1111.
  - Source enum SRC_NONE/SRC_A/SRC_B (2-bit).
  - Function onecold(idx) returning the active-low anode pattern.
- Sub-module display_src_arbiter:
  - Inputs: req_a, req_b, data_a, data_b, and the boundary strobe.
  - Holds the owner state and frame_buf.
  - Outputs: grants and frame_buf.
- The scheduler top holds slot_cnt, idx, the phase/blank logic and the output registers.

Test Plan (SLOT_LOG2=5, BLANK_CYCLES=2 for sim):
- Reset and idle: rst 3 cycles then release, no requests.
  - an pattern per slot is 1111 for 2 clocks, then 1110/1101/1011/0111 on successive slots.
  - digit=0 throughout.
  - frame_done pulses every 128 clocks.
- Brightness: brightness=0.
  - Each slot has an active only for slot_cnt 2..3 (2 clocks).
  - brightness=7: active for slot_cnt 2..31 (30 clocks).
- Arbitration hold: req_a=1 with data_a=16'h1234, then req_b=1 mid-frame with data_b=16'hBEEF.
  - grant_a=1 from the first boundary; digits show 4,3,2,1.
  - grant stays with A while req_a=1.
  - Drop req_a: at the next boundary grant_b=1 and digits show F,E,E,B.
- Simultaneous request: from idle, req_a and req_b rise together.
  - A is granted at the boundary; grant_b stays 0.
  - Data change on data_a mid-frame is not visible until the following frame.
- Leading-zero blanking: lz_blank=1, value 16'h0005 shows only digit 0. 16'h0000 shows only digit 0 = "0". 16'h0105 shows digits 0..2, and digit 1 shows "0".
- Mid-frame reset: assert rst while idx=2, slot_cnt=10.
  - Next edge: an=1111, grants=0.
  - After release the scan restarts at idx 0 and frame_buf=0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan scheduler.
package display_pkg;

  localparam int DIGITS = 4;
  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_A    = 2'd1,
    SRC_B    = 2'd2
  } src_t;

  // Active-low anode pattern: only the selected digit's bit is driven low.
  function automatic logic [3:0] onecold(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/display_src_arbiter.sv
// Frame-boundary arbiter between the operand view (A) and the sum view (B);
// latches the winner's value so a whole frame is drawn from one source.
module display_src_arbiter
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        boundary,
  input  logic        req_a,
  input  logic [15:0] data_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  output logic        grant_a,
  output logic        grant_b,
  output logic [15:0] frame_buf
);

  src_t owner;
  src_t next_owner;

  // A current owner that still requests keeps the display; otherwise A has priority.
  always_comb begin
    next_owner = SRC_NONE;
    if ((owner == SRC_A && req_a) || (owner == SRC_B && req_b)) begin
      next_owner = owner;
    end else if (req_a) begin
      next_owner = SRC_A;
    end else if (req_b) begin
      next_owner = SRC_B;
    end
  end

  // With no new owner the buffer keeps the last frame shown.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= SRC_NONE;
      grant_a   <= 1'b0;
      grant_b   <= 1'b0;
      frame_buf <= '0;
    end else if (boundary) begin
      owner   <= next_owner;
      grant_a <= (next_owner == SRC_A);
      grant_b <= (next_owner == SRC_B);
      case (next_owner)
        SRC_A:   frame_buf <= data_a;
        SRC_B:   frame_buf <= data_b;
        default: frame_buf <= frame_buf;
      endcase
    end
  end

endmodule

// File: rtl/display_scan_scheduler.sv
// Digit scan sequencer: slot/digit counters, anti-ghost blanking, PWM
// brightness and leading-zero suppression for a 4-digit multiplexed display.
module display_scan_scheduler
  import display_pkg::*;
#(
  parameter int SLOT_LOG2    = 16,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [15:0] data_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  input  logic [2:0]  brightness,
  input  logic        lz_blank,
  output logic        grant_a,
  output logic        grant_b,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam logic [SLOT_LOG2-1:0] SLOT_MAX  = '1;
  localparam logic [SLOT_LOG2-1:0] BLANK_END = SLOT_LOG2'(BLANK_CYCLES);
  localparam logic [1:0]           LAST_IDX  = 2'(DIGITS - 1);

  logic [SLOT_LOG2-1:0] slot_cnt;
  logic [1:0]           idx;
  logic                 boundary;
  logic [15:0]          frame_buf;
  logic [2:0]           phase;
  logic                 blank;
  logic                 suppressed;
  logic                 lit;
  logic [3:0]           cur_nibble;

  assign boundary   = (idx == LAST_IDX) && (slot_cnt == SLOT_MAX);
  assign phase      = slot_cnt[SLOT_LOG2-1 -: 3];
  assign blank      = (slot_cnt < BLANK_END);
  assign cur_nibble = frame_buf[{idx, 2'b00} +: 4];

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    suppressed = 1'b0;
    case (idx)
      2'd1:    suppressed = (frame_buf[15:4]  == 12'h000);
      2'd2:    suppressed = (frame_buf[15:8]  == 8'h00);
      2'd3:    suppressed = (frame_buf[15:12] == 4'h0);
      default: suppressed = 1'b0;
    endcase
  end

  assign lit = !blank && (phase <= brightness) && !(lz_blank && suppressed);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_cnt == SLOT_MAX) begin
      slot_cnt <= '0;
      idx      <= (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // The nibble follows idx even while dark so the decoder settles before the anode turns on.
  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= AN_OFF;
      digit      <= 4'h0;
      frame_done <= 1'b0;
    end else begin
      an         <= lit ? onecold(idx) : AN_OFF;
      digit      <= cur_nibble;
      frame_done <= boundary;
    end
  end

  display_src_arbiter u_arbiter (
    .clk       (clk),
    .rst       (rst),
    .boundary  (boundary),
    .req_a     (req_a),
    .data_a    (data_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .grant_a   (grant_a),
    .grant_b   (grant_b),
    .frame_buf (frame_buf)
  );

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Self-checking bench: a frame-position model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_display_scan_scheduler;

  localparam int SLOT_LOG2    = 5;
  localparam int BLANK_CYCLES = 2;
  localparam int SLOT_LEN     = 1 << SLOT_LOG2;
  localparam int FRAME_LEN    = 4 * SLOT_LEN;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0;
  logic [15:0] data_a = 16'h0;
  logic        req_b = 1'b0;
  logic [15:0] data_b = 16'h0;
  logic [2:0]  brightness = 3'd7;
  logic        lz_blank = 1'b0;
  logic        grant_a;
  logic        grant_b;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        frame_done;

  int n_compared = 0;
  int n_mismatched = 0;

  display_scan_scheduler #(
    .SLOT_LOG2    (SLOT_LOG2),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_a      (req_a),
    .data_a     (data_a),
    .req_b      (req_b),
    .data_b     (data_b),
    .brightness (brightness),
    .lz_blank   (lz_blank),
    .grant_a    (grant_a),
    .grant_b    (grant_b),
    .digit      (digit),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Model: position within the frame drives everything; owner 0=none 1=A 2=B.
  bit          model_on = 1'b0;
  int          pos = 0;
  int          owner = 0;
  int          m_sc;
  int          m_ix;
  bit          m_sup;
  logic [15:0] shown = 16'h0;
  logic [3:0]  exp_an = 4'hF;
  logic [3:0]  exp_digit = 4'h0;
  logic        exp_ga = 1'b0;
  logic        exp_gb = 1'b0;
  logic        exp_fd = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      model_on  = 1'b1;
      pos       = 0;
      owner     = 0;
      shown     = 16'h0;
      exp_an    = 4'hF;
      exp_digit = 4'h0;
      exp_ga    = 1'b0;
      exp_gb    = 1'b0;
      exp_fd    = 1'b0;
    end else if (model_on) begin
      m_sc      = pos % SLOT_LEN;
      m_ix      = pos / SLOT_LEN;
      m_sup     = lz_blank && (m_ix > 0) && ((shown >> (4 * m_ix)) == 16'h0);
      exp_digit = 4'((shown >> (4 * m_ix)) & 16'hF);
      if (m_sc >= BLANK_CYCLES && (m_sc / (SLOT_LEN / 8)) <= int'(brightness) && !m_sup)
        exp_an = ~(4'b0001 << m_ix);
      else
        exp_an = 4'hF;
      exp_fd = (pos == FRAME_LEN - 1);
      if (pos == FRAME_LEN - 1) begin
        if (!((owner == 1 && req_a) || (owner == 2 && req_b)))
          owner = req_a ? 1 : (req_b ? 2 : 0);
        if (owner == 1) shown = data_a;
        else if (owner == 2) shown = data_b;
      end
      exp_ga = (owner == 1);
      exp_gb = (owner == 2);
      pos    = (pos + 1) % FRAME_LEN;
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("model_an", an, exp_an);
      checkOutput("model_digit", digit, exp_digit);
      checkOutput("model_grant_a", {3'b000, grant_a}, {3'b000, exp_ga});
      checkOutput("model_grant_b", {3'b000, grant_b}, {3'b000, exp_gb});
      checkOutput("model_frame_done", {3'b000, frame_done}, {3'b000, exp_fd});
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns on the negedge where frame_done is high (offset 0 of the new frame).
  task automatic waitFrame();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_done !== 1'b1 && k < 2 * FRAME_LEN);
    if (frame_done !== 1'b1) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL frame_timeout: got no frame_done, expected one within %0d cycles", 2 * FRAME_LEN);
    end
  endtask

  task automatic applyStimulus(input logic ra, input logic [15:0] da, input logic rb,
                               input logic [15:0] db, input logic [2:0] br, input logic lz);
    req_a      = ra;
    data_a     = da;
    req_b      = rb;
    data_b     = db;
    brightness = br;
    lz_blank   = lz;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 3'd7, 1'b0);
    waitCycles(3);
    checkOutput("reset_an", an, 4'hF);
    checkOutput("reset_digit", digit, 4'h0);
    checkOutput("reset_grants", {2'b00, grant_a, grant_b}, 4'h0);
    checkOutput("reset_fd", {3'b000, frame_done}, 4'h0);
    rst = 1'b0;

    // Idle scan with full brightness
    waitCycles(2);  checkOutput("idle_blank", an, 4'hF);
    waitCycles(1);  checkOutput("idle_d0", an, 4'hE);
    waitCycles(32); checkOutput("idle_d1", an, 4'hD);
    waitCycles(32); checkOutput("idle_d2", an, 4'hB);
    waitCycles(32); checkOutput("idle_d3", an, 4'h7);
    checkOutput("idle_digit", digit, 4'h0);
    waitCycles(29); checkOutput("idle_fd_hi", {3'b000, frame_done}, 4'h1);
    waitCycles(1);  checkOutput("idle_fd_lo", {3'b000, frame_done}, 4'h0);
    checkOutput("idle_wrap_blank", an, 4'hF);

    // Minimum brightness: only slot_cnt 2..3 lit
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 3'd0, 1'b0);
    waitCycles(2); checkOutput("dim_sc2", an, 4'hE);
    waitCycles(1); checkOutput("dim_sc3", an, 4'hE);
    waitCycles(1); checkOutput("dim_sc4", an, 4'hF);

    // Arbitration hold: A owns, B requests mid-frame
    applyStimulus(1'b1, 16'h1234, 1'b0, 16'h0, 3'd7, 1'b0);
    waitFrame();
    checkOutput("hold_ga", {3'b000, grant_a}, 4'h1);
    checkOutput("hold_gb", {3'b000, grant_b}, 4'h0);
    waitCycles(1);
    checkOutput("hold_dig0", digit, 4'h4);
    waitCycles(9);
    applyStimulus(1'b1, 16'h1234, 1'b1, 16'hBEEF, 3'd7, 1'b0);
    waitCycles(23); checkOutput("hold_dig1", digit, 4'h3);
    waitCycles(32); checkOutput("hold_dig2", digit, 4'h2);
    waitCycles(32); checkOutput("hold_dig3", digit, 4'h1);
    waitFrame();
    checkOutput("keep_ga", {3'b000, grant_a}, 4'h1);
    checkOutput("keep_gb", {3'b000, grant_b}, 4'h0);
    applyStimulus(1'b0, 16'h1234, 1'b1, 16'hBEEF, 3'd7, 1'b0);
    waitFrame();
    checkOutput("switch_ga", {3'b000, grant_a}, 4'h0);
    checkOutput("switch_gb", {3'b000, grant_b}, 4'h1);
    waitCycles(1);  checkOutput("beef_dig0", digit, 4'hF);
    waitCycles(32); checkOutput("beef_dig1", digit, 4'hE);
    waitCycles(32); checkOutput("beef_dig2", digit, 4'hE);
    waitCycles(32); checkOutput("beef_dig3", digit, 4'hB);

    // Release everything: no owner, buffer keeps BEEF
    applyStimulus(1'b0, 16'h1234, 1'b0, 16'hBEEF, 3'd7, 1'b0);
    waitFrame();
    checkOutput("none_grants", {2'b00, grant_a, grant_b}, 4'h0);
    waitCycles(1);
    checkOutput("none_hold_buf", digit, 4'hF);

    // Simultaneous request from idle: A wins, mid-frame data change deferred
    applyStimulus(1'b1, 16'h00A1, 1'b1, 16'hFFFF, 3'd7, 1'b0);
    waitFrame();
    checkOutput("simul_ga", {3'b000, grant_a}, 4'h1);
    checkOutput("simul_gb", {3'b000, grant_b}, 4'h0);
    waitCycles(10);
    applyStimulus(1'b1, 16'h5678, 1'b1, 16'hFFFF, 3'd7, 1'b0);
    waitCycles(23); checkOutput("simul_old_data", digit, 4'hA);
    waitFrame();
    waitCycles(1);  checkOutput("simul_new_data", digit, 4'h8);

    // Leading-zero suppression
    applyStimulus(1'b1, 16'h0005, 1'b0, 16'h0, 3'd7, 1'b1);
    waitFrame();
    waitCycles(3);  checkOutput("lz5_an0", an, 4'hE);
    checkOutput("lz5_dig0", digit, 4'h5);
    waitCycles(32); checkOutput("lz5_an1", an, 4'hF);
    applyStimulus(1'b1, 16'h0000, 1'b0, 16'h0, 3'd7, 1'b1);
    waitFrame();
    waitCycles(3);  checkOutput("lz0_an0", an, 4'hE);
    checkOutput("lz0_dig0", digit, 4'h0);
    waitCycles(64); checkOutput("lz0_an2", an, 4'hF);
    applyStimulus(1'b1, 16'h0105, 1'b0, 16'h0, 3'd7, 1'b1);
    waitFrame();
    waitCycles(35); checkOutput("lz105_an1", an, 4'hD);
    checkOutput("lz105_dig1", digit, 4'h0);
    waitCycles(32); checkOutput("lz105_an2", an, 4'hB);
    checkOutput("lz105_dig2", digit, 4'h1);
    waitCycles(32); checkOutput("lz105_an3", an, 4'hF);

    // Mid-frame reset at idx=2, slot_cnt=10
    waitFrame();
    waitCycles(74);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("midrst_an", an, 4'hF);
    checkOutput("midrst_grants", {2'b00, grant_a, grant_b}, 4'h0);
    checkOutput("midrst_fd", {3'b000, frame_done}, 4'h0);
    checkOutput("midrst_digit", digit, 4'h0);
    rst = 1'b0;
    waitCycles(3);
    checkOutput("restart_an", an, 4'hE);
    checkOutput("restart_digit", digit, 4'h0);
    checkOutput("restart_ga", {3'b000, grant_a}, 4'h0);
    waitCycles(32);
    checkOutput("restart_buf_zero", an, 4'hF);
    waitFrame();
    checkOutput("regrant_ga", {3'b000, grant_a}, 4'h1);
    waitCycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
